// File: rtl/sm83_bus.sv
// Memory-cycle bus controller for the SM83 core: decodes each T1..T4 cycle into
// boot ROM, HRAM, IE, I/O register bus or external bus and sequences the strobes.
module sm83_bus #(
    parameter int unsigned HRAM_WORDS    = 127,
    parameter int unsigned BOOT_SIZE     = 256,
    parameter logic [15:0] BOOT_OFF_ADDR = 16'hFF50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] aout,
    input  logic [7:0]  ext_dout,
    output logic [7:0]  ext_din,
    output logic [7:0]  iena,
    output logic        iena_sel,
    output logic        boot_en,
    output logic [7:0]  boot_a,
    input  logic [7:0]  boot_d,
    output logic [6:0]  io_a,
    output logic [7:0]  io_dout,
    input  logic [7:0]  io_din,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_d_oe,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        bus_cs
);

    localparam int unsigned HW = $clog2(HRAM_WORDS);

    typedef enum logic { S_IDLE, S_ACTIVE } state_t;
    typedef enum logic [2:0] { R_BOOT, R_IO, R_BOOTREG, R_HRAM, R_IE, R_EXT } region_t;

    state_t        state_q, state_d;
    region_t       region_q, region_d, region_new;
    logic          wr_q, wr_d;
    logic [HW-1:0] hram_idx_q, hram_idx_d;
    logic          boot_en_q, boot_en_d;
    logic [7:0]    iena_q, iena_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    boot_a_q, boot_a_d;
    logic [6:0]    io_a_q, io_a_d;
    logic [7:0]    io_dout_q, io_dout_d;
    logic          io_rd_q, io_rd_d, io_wr_q, io_wr_d;
    logic [15:0]   bus_a_q, bus_a_d;
    logic [7:0]    bus_dout_q, bus_dout_d;
    logic          bus_d_oe_q, bus_d_oe_d;
    logic          bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d, bus_cs_q, bus_cs_d;

    logic [7:0]    hram [HRAM_WORDS];
    logic [31:0]   aout32;
    logic [7:0]    sel_data;
    logic          hram_we;

    assign aout32 = {16'd0, aout};

    // IE and BOOTREG are tested ahead of the wider ranges that contain them.
    always_comb begin
        region_new = R_EXT;
        if (aout == 16'hFFFF)
            region_new = R_IE;
        else if (aout32 >= 32'hFF80 && aout32 < 32'hFF80 + HRAM_WORDS)
            region_new = R_HRAM;
        else if (aout == BOOT_OFF_ADDR)
            region_new = R_BOOTREG;
        else if (aout[15:7] == 9'b1111_1111_0)
            region_new = R_IO;
        else if (aout32 < BOOT_SIZE && !wr && boot_en_q)
            region_new = R_BOOT;
    end

    always_comb begin
        sel_data = rdata_q;
        case (region_q)
            R_BOOT:    sel_data = boot_d;
            R_IO:      sel_data = io_din;
            R_HRAM:    sel_data = hram[hram_idx_q];
            R_BOOTREG: sel_data = {7'h7F, ~boot_en_q};
            R_EXT:     sel_data = bus_din;
            default:   sel_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        wr_d       = wr_q;
        hram_idx_d = hram_idx_q;
        boot_en_d  = boot_en_q;
        iena_d     = iena_q;
        rdata_d    = rdata_q;
        boot_a_d   = boot_a_q;
        io_a_d     = io_a_q;
        io_dout_d  = io_dout_q;
        io_rd_d    = io_rd_q;
        io_wr_d    = io_wr_q;
        bus_a_d    = bus_a_q;
        bus_dout_d = bus_dout_q;
        bus_d_oe_d = bus_d_oe_q;
        bus_rd_d   = bus_rd_q;
        bus_wr_d   = bus_wr_q;
        bus_cs_d   = bus_cs_q;
        case (state_q)
            S_IDLE: begin
                if (t1 && (rd || wr)) begin
                    state_d    = S_ACTIVE;
                    region_d   = region_new;
                    wr_d       = wr;
                    hram_idx_d = aout[HW-1:0];
                    if (region_new == R_EXT) begin
                        bus_a_d    = aout;
                        bus_cs_d   = 1'b1;
                        bus_rd_d   = !wr;
                        bus_d_oe_d = wr;
                        if (wr) bus_dout_d = ext_dout;
                    end
                    if (region_new == R_IO) begin
                        io_a_d  = aout[6:0];
                        io_rd_d = !wr;
                        if (wr) io_dout_d = ext_dout;
                    end
                    if (region_new == R_BOOT) boot_a_d = aout[7:0];
                end
            end
            S_ACTIVE: begin
                if (t2) begin
                    bus_wr_d = (region_q == R_EXT) && wr_q;
                    io_wr_d  = (region_q == R_IO) && wr_q;
                end
                if (t3) begin
                    bus_cs_d = 1'b0;
                    bus_rd_d = 1'b0;
                    bus_wr_d = 1'b0;
                    io_rd_d  = 1'b0;
                    io_wr_d  = 1'b0;
                    if (!wr_q) rdata_d = sel_data;
                    if (wr_q && region_q == R_IE) iena_d = ext_dout;
                    if (wr_q && region_q == R_BOOTREG && ext_dout != 8'h00) boot_en_d = 1'b0;
                end
                if (t4) begin
                    bus_d_oe_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            region_q   <= R_EXT;
            wr_q       <= 1'b0;
            hram_idx_q <= '0;
            boot_en_q  <= 1'b1;
            iena_q     <= '0;
            rdata_q    <= '0;
            boot_a_q   <= '0;
            io_a_q     <= '0;
            io_dout_q  <= '0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            bus_a_q    <= '0;
            bus_dout_q <= '0;
            bus_d_oe_q <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            bus_cs_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            wr_q       <= wr_d;
            hram_idx_q <= hram_idx_d;
            boot_en_q  <= boot_en_d;
            iena_q     <= iena_d;
            rdata_q    <= rdata_d;
            boot_a_q   <= boot_a_d;
            io_a_q     <= io_a_d;
            io_dout_q  <= io_dout_d;
            io_rd_q    <= io_rd_d;
            io_wr_q    <= io_wr_d;
            bus_a_q    <= bus_a_d;
            bus_dout_q <= bus_dout_d;
            bus_d_oe_q <= bus_d_oe_d;
            bus_rd_q   <= bus_rd_d;
            bus_wr_q   <= bus_wr_d;
            bus_cs_q   <= bus_cs_d;
        end
    end

    // HRAM keeps its contents through reset; a held reset still blocks the T3 write.
    assign hram_we = (state_q == S_ACTIVE) && t3 && wr_q && (region_q == R_HRAM) && !reset;

    always_ff @(posedge clk) begin
        if (hram_we) hram[hram_idx_q] <= ext_dout;
    end

    assign ext_din  = rdata_q;
    assign iena     = iena_q;
    assign iena_sel = (state_q == S_ACTIVE) && (region_q == R_IE) && !wr_q;
    assign boot_en  = boot_en_q;
    assign boot_a   = boot_a_q;
    assign io_a     = io_a_q;
    assign io_dout  = io_dout_q;
    assign io_rd    = io_rd_q;
    assign io_wr    = io_wr_q;
    assign bus_a    = bus_a_q;
    assign bus_dout = bus_dout_q;
    assign bus_d_oe = bus_d_oe_q;
    assign bus_rd   = bus_rd_q;
    assign bus_wr   = bus_wr_q;
    assign bus_cs   = bus_cs_q;

endmodule

// File: tb/tb_sm83_bus.sv
// Bench for sm83_bus: directed test-plan cycles followed by random cycles, all
// checked phase by phase against a memory-map model of the bus controller.
module tb_sm83_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        t1, t2, t3, t4, rd, wr;
    logic [15:0] aout;
    logic [7:0]  ext_dout, ext_din, iena, boot_a, boot_d, io_dout, io_din;
    logic [7:0]  bus_dout, bus_din;
    logic        iena_sel, boot_en, io_rd, io_wr, bus_d_oe, bus_rd, bus_wr, bus_cs;
    logic [6:0]  io_a;
    logic [15:0] bus_a;

    int checks = 0;
    int failures = 0;

    // Model state: architectural registers and memories as the CPU sees them.
    logic [7:0]  m_hram [128];
    logic [7:0]  m_iena;
    logic        m_boot_en;
    logic [15:0] m_bus_a;
    logic [7:0]  m_hold;
    logic        m_hold_ok;

    sm83_bus #(.HRAM_WORDS(127), .BOOT_SIZE(256), .BOOT_OFF_ADDR(16'hFF50)) dut (
        .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .rd(rd), .wr(wr), .aout(aout), .ext_dout(ext_dout), .ext_din(ext_din),
        .iena(iena), .iena_sel(iena_sel), .boot_en(boot_en), .boot_a(boot_a),
        .boot_d(boot_d), .io_a(io_a), .io_dout(io_dout), .io_din(io_din),
        .io_rd(io_rd), .io_wr(io_wr), .bus_a(bus_a), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_d_oe(bus_d_oe), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_cs(bus_cs)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] boot_rom(input logic [7:0] a);
        return (a * 8'h0D) + 8'h31;
    endfunction

    assign boot_d = boot_rom(boot_a);

    // 0 BOOT, 1 IO, 2 BOOTREG, 3 HRAM, 4 IE, 5 EXT
    function automatic int region_of(input logic [15:0] a, input logic w, input logic ben);
        if (a == 16'hFFFF) return 4;
        if (a >= 16'hFF80) return 3;
        if (a == 16'hFF50) return 2;
        if (a >= 16'hFF00) return 1;
        if (a < 16'h0100 && !w && ben) return 0;
        return 5;
    endfunction

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_iena    = 8'h00;
        m_boot_en = 1'b1;
        m_bus_a   = 16'h0000;
        m_hold    = 8'h00;
        m_hold_ok = 1'b1;
    endtask

    // rg = -1 means no cycle in progress.
    task automatic pcheck(input string p, input int rg, input logic w, input int k,
                          input logic [15:0] a, input logic [7:0] d);
        logic mid, ext, io;
        mid = (k == 2) || (k == 3);
        ext = (rg == 5);
        io  = (rg == 1);
        chkb({p, ".bus_cs"}, bus_cs, ext && mid);
        chkb({p, ".bus_rd"}, bus_rd, ext && !w && mid);
        chkb({p, ".bus_wr"}, bus_wr, ext && w && (k == 3));
        chkb({p, ".bus_d_oe"}, bus_d_oe, ext && w && (k >= 2));
        chkb({p, ".io_rd"}, io_rd, io && !w && mid);
        chkb({p, ".io_wr"}, io_wr, io && w && (k == 3));
        chkb({p, ".iena_sel"}, iena_sel, (rg == 4) && !w && (k >= 2));
        chk16({p, ".bus_a"}, bus_a, m_bus_a);
        chk8({p, ".iena"}, iena, m_iena);
        chkb({p, ".boot_en"}, boot_en, m_boot_en);
        if (m_hold_ok) chk8({p, ".ext_din"}, ext_din, m_hold);
        if (ext && w && k >= 2) chk8({p, ".bus_dout"}, bus_dout, d);
        if (io && k >= 2) chk8({p, ".io_a"}, {1'b0, io_a}, {1'b0, a[6:0]});
        if (io && w && k >= 2) chk8({p, ".io_dout"}, io_dout, d);
        if (rg == 0 && k >= 2) chk8({p, ".boot_a"}, boot_a, a[7:0]);
    endtask

    task automatic cycle(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] bdin, input logic [7:0] idin);
        int rg;
        logic [7:0] exp_rd;
        rg = region_of(a, w, m_boot_en);
        case (rg)
            0:       exp_rd = boot_rom(a[7:0]);
            1:       exp_rd = idin;
            2:       exp_rd = {7'h7F, ~m_boot_en};
            3:       exp_rd = m_hram[a - 16'hFF80];
            default: exp_rd = bdin;
        endcase
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            t1 = (k == 1); t2 = (k == 2); t3 = (k == 3); t4 = (k == 4);
            if (k == 1) begin
                rd = r; wr = w; aout = a; ext_dout = d; bus_din = bdin; io_din = idin;
            end
            #2;
            if (k == 2 && rg == 5) m_bus_a = a;
            if (k == 4) begin
                if (w) begin
                    if (rg == 3) m_hram[a - 16'hFF80] = d;
                    if (rg == 4) m_iena = d;
                    if (rg == 2 && d != 8'h00) m_boot_en = 1'b0;
                end else if (rg == 4) begin
                    m_hold_ok = 1'b0;
                end else begin
                    m_hold    = exp_rd;
                    m_hold_ok = 1'b1;
                end
            end
            pcheck($sformatf("cyc@%h.T%0d", a, k), rg, w, k, a, d);
        end
    endtask

    task automatic idle_cycle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            t1 = (k == 1); t2 = (k == 2); t3 = (k == 3); t4 = (k == 4);
            rd = 1'b0; wr = 1'b0; aout = 16'($urandom); ext_dout = 8'($urandom);
            #2;
            pcheck($sformatf("idle.T%0d", k), -1, 1'b0, k, aout, ext_dout);
        end
    endtask

    task automatic start_and_reset_in_t2(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        t1 = 1'b1; t2 = 1'b0; t3 = 1'b0; t4 = 1'b0;
        rd = 1'b0; wr = 1'b1; aout = a; ext_dout = d;
        @(negedge clk);
        t1 = 1'b0; t2 = 1'b1;
        #2;
        if (region_of(a, 1'b1, m_boot_en) == 5) chkb("rst_mid.bus_cs_before", bus_cs, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        pcheck("rst_mid", -1, 1'b0, 1, a, d);
        @(negedge clk);
        reset = 1'b0;
        t1 = 1'b0; t2 = 1'b0; t3 = 1'b0; t4 = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          b, kind;

        reset = 1'b1;
        t1 = 1'b0; t2 = 1'b0; t3 = 1'b0; t4 = 1'b0; rd = 1'b0; wr = 1'b0;
        aout = '0; ext_dout = '0; io_din = '0; bus_din = '0;
        model_reset();
        #12;
        pcheck("reset", -1, 1'b0, 1, 16'h0000, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        cycle(1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 16'hFF50, 8'h01, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 16'h0000, 8'h00, 8'hC3, 8'h00);
        cycle(1'b0, 1'b1, 16'hFF80, 8'hA5, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 16'hFF80, 8'h00, 8'h11, 8'h22);
        cycle(1'b0, 1'b1, 16'hFFFF, 8'h1F, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 16'hC000, 8'h5A, 8'h00, 8'h00);
        cycle(1'b1, 1'b1, 16'hFF10, 8'h3C, 8'h00, 8'h44);
        cycle(1'b1, 1'b0, 16'hFF10, 8'h00, 8'h00, 8'h6E);
        cycle(1'b1, 1'b0, 16'hFF50, 8'h00, 8'h00, 8'h00);
        idle_cycle();

        cycle(1'b0, 1'b1, 16'hFF90, 8'h77, 8'h00, 8'h00);
        start_and_reset_in_t2(16'hFF90, 8'h88);
        cycle(1'b1, 1'b0, 16'hFF90, 8'h00, 8'h00, 8'h00);
        start_and_reset_in_t2(16'hC123, 8'h3C);
        cycle(1'b1, 1'b0, 16'h0042, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 127; i++)
            cycle(1'b0, 1'b1, 16'hFF80 + 16'(i), 8'($urandom), 8'h00, 8'h00);

        for (int n = 0; n < 250; n++) begin
            b = $urandom_range(0, 5);
            case (b)
                0:       a = {8'h00, 8'($urandom)};
                1:       a = {9'b1111_1111_0, 7'($urandom)};
                2:       a = 16'hFF50;
                3:       a = 16'hFF80 + 16'($urandom_range(0, 126));
                4:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            kind = $urandom_range(0, 2);
            d = 8'($urandom);
            if (b == 2 && $urandom_range(0, 3) != 0) d = 8'h00;
            cycle(kind != 1, kind != 0, a, d, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm83_bus.md
Name: sm83_bus

Overview:
- Memory-cycle bus controller directly downstream of the CPU I/O stage.
- Consumes the CPU's rd/wr strobes, address (aout) and write data (ext_dout), sequenced by the T1..T4 phase flags.
- Decodes each cycle into one target: boot ROM, internal HRAM, IE register, I/O register bus, or external bus.
- Returns read data on ext_din, and the IE value plus its select on iena/iena_sel.

Parameters:
- HRAM_WORDS, 127, HRAM depth; maps FF80..FF80+HRAM_WORDS-1.
- BOOT_SIZE, 256, boot ROM overlay size from 0000.
- BOOT_OFF_ADDR, 16'hFF50, boot-disable register address.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- t1, t2, t3, t4  in  1 each  one-hot T-phase flags
- rd, wr  in  1 each  CPU cycle strobes, stable T1..T4 of a cycle
- aout  in  16  CPU address
- ext_dout  in  8  CPU write data
- ext_din  out  8  read data to CPU, valid in T4
- iena  out  8  IE register contents
- iena_sel  out  1  current cycle is a read of FFFF
- boot_en  out  1  boot ROM overlay active
- boot_a  out  8  boot ROM address
- boot_d  in  8  boot ROM data, combinational from boot_a
- io_a  out  7  I/O register offset (A-FF00)
- io_dout  out  8  I/O write data
- io_din  in  8  I/O read data
- io_rd, io_wr  out  1 each  I/O strobes
- bus_a  out  16  external address
- bus_dout  out  8  external write data
- bus_din  in  8  external read data
- bus_d_oe  out  1  external data drive enable
- bus_rd, bus_wr, bus_cs  out  1 each  external strobes

Behaviour:
- Tn denotes the clock period in which tn is high. All outputs except ext_din and iena_sel are registered.
- Reset (asynchronous): FSM to IDLE; boot_en=1; iena=0; ext_din=0; all strobes, bus_d_oe and iena_sel =0; bus_a=0. HRAM contents are not reset.
- Mid-cycle reset: strobes drop immediately and the cycle is abandoned. No HRAM/IE write occurs unless the T3 edge has already passed.

Cycle start:
- At the posedge in T1 with rd|wr: latch A=aout and kind (wr wins if both are high) and decode the region.
  - 0000..BOOT_SIZE-1 and read and boot_en: BOOT.
  - FF00..FF7F: IO, except BOOT_OFF_ADDR, which is BOOTREG.
  - FF80..FF80+HRAM_WORDS-1: HRAM.
  - FFFF: IE.
  - All else, including writes into the boot range: EXT.
- FSM: IDLE -> ACTIVE at the T1 edge -> IDLE at the T4 edge. rd|wr high at the next T1 starts the next cycle back-to-back.
- t-flags outside a cycle are ignored.

Strobe timing:
- EXT read: bus_cs, bus_rd high in T2..T3.
- EXT write: bus_cs T2..T3; bus_wr T3 only; bus_d_oe and bus_dout=ext_dout T2..T4.
- bus_a=A from T2 and held after the cycle.
- IO: io_a and io_dout follow the same timing; io_rd T2..T3; io_wr T3 only.
- BOOT: boot_a=A[7:0].

Read data:
- At the T3 posedge, capture the selected source (boot_d, io_din, hram[A-FF80], bus_din, or BOOTREG={7'h7F,~boot_en}) into rdata.
- ext_din=rdata, holding its last value outside T4.
- IE read: iena_sel=1 from T2 through T4, combinationally from the latched decode; ext_din is don't-care.

Writes (commit at the T3 posedge):
- HRAM: hram[A-FF80]<=ext_dout.
- IE: iena<=ext_dout.
- BOOTREG: ext_dout!=0 clears boot_en. boot_en is sticky until reset. BOOTREG is not forwarded to IO.

Other:
- Unmapped bits: none; every address decodes.
- Read-after-write to the same HRAM address in the next cycle returns the new value.

Test Plan:
- Reset, read 0000 with boot_d=8'h31 -> ext_din=8'h31 in T4; no bus_rd/bus_cs pulse; boot_en=1.
- Write FF50=8'h01, then read 0000 with bus_din=8'hC3 -> boot_en=0 after the T3 edge; second cycle bus_cs/bus_rd high T2..T3 and ext_din=8'hC3.
- Write FF80=8'hA5, then back-to-back read FF80 -> ext_din=8'hA5; no io/bus strobes in either cycle.
- Write FFFF=8'h1F, then read FFFF -> iena=8'h1F after the first T3 edge; iena_sel=1 in T2..T4 of the read only.
- Write C000=8'h5A -> bus_a=16'hC000 from T2; bus_dout=8'h5A with bus_d_oe T2..T4; bus_wr only in T3.
- Assert reset during T2 of a write to FF90 -> strobes low immediately, hram[0x10] unchanged, boot_en=1, iena=0.
